// File: rtl/arch_reg_rename_pkg.sv
// arch_reg_rename_pkg: shared widths and bundles for the register file and rename table
package arch_reg_rename_pkg;
  localparam int REG_WIDTH = 5;
  localparam int ROB_WIDTH = 4;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS = 2 ** REG_WIDTH;
  typedef struct packed {
    logic                 busy;
    logic [ROB_WIDTH-1:0] tag;
  } reg_status_t;
  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } operand_t;
endpackage

// File: rtl/arch_reg_read_mux.sv
// arch_reg_read_mux: resolves one operand to a value (zero reg, register, ROB, CDB) or a pending tag
module arch_reg_read_mux
  import arch_reg_rename_pkg::*;
(
  input  logic                  is_zero,
  input  reg_status_t           status,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic                  rob_valid,
  input  logic [DATA_WIDTH-1:0] rob_data,
  input  logic                  cdb_valid,
  input  logic [ROB_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  output operand_t              op
);
  logic cdb_hit;
  assign cdb_hit = cdb_valid && cdb_tag == status.tag;
  assign op.valid = is_zero || !status.busy || rob_valid || cdb_hit;
  assign op.tag = status.tag;
  assign op.data = is_zero      ? '0 :
                   !status.busy ? reg_data :
                   rob_valid    ? rob_data :
                   cdb_hit      ? cdb_data : '0;
endmodule

// File: rtl/arch_reg_rename.sv
// arch_reg_rename: architectural register file with rename status and ROB/CDB operand bypass
module arch_reg_rename
  import arch_reg_rename_pkg::*;
#(
  parameter int N_READ = 2,
  parameter bit HAS_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [REG_WIDTH-1:0]  rd_num    [N_READ],
  output logic                  rd_valid  [N_READ],
  output logic [ROB_WIDTH-1:0]  rd_tag    [N_READ],
  output logic [DATA_WIDTH-1:0] rd_data   [N_READ],
  output logic [ROB_WIDTH-1:0]  rob_tag   [N_READ],
  input  logic                  rob_valid [N_READ],
  input  logic [DATA_WIDTH-1:0] rob_data  [N_READ],
  input  logic                  cdb_valid,
  input  logic [ROB_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic                  issue,
  input  logic                  issue_dest_we,
  input  logic [REG_WIDTH-1:0]  issue_dest,
  input  logic [ROB_WIDTH-1:0]  issue_tag,
  input  logic                  commit,
  input  logic [REG_WIDTH-1:0]  commit_arch_num,
  input  logic [ROB_WIDTH-1:0]  commit_tag,
  input  logic [DATA_WIDTH-1:0] commit_data
);
  logic [DATA_WIDTH-1:0] data [NUM_REGS];
  reg_status_t status [NUM_REGS];
  logic issue_ok, commit_ok;
  assign issue_ok = issue && issue_dest_we && !flush && !(HAS_ZERO && issue_dest == '0);
  assign commit_ok = commit && !(HAS_ZERO && commit_arch_num == '0);
  // Later assignments win: issue overrides the commit's busy clear on the same register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data[i] <= '0;
        status[i] <= '0;
      end
    end else begin
      if (commit_ok) begin
        data[commit_arch_num] <= commit_data;
        if (status[commit_arch_num].tag == commit_tag) status[commit_arch_num].busy <= 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < NUM_REGS; i++) status[i].busy <= 1'b0;
      end else if (issue_ok) begin
        status[issue_dest] <= '{busy: 1'b1, tag: issue_tag};
      end
    end
  end
  for (genvar g = 0; g < N_READ; g++) begin : g_rd
    operand_t op;
    arch_reg_read_mux u_mux (
      .is_zero   (HAS_ZERO && rd_num[g] == '0),
      .status    (status[rd_num[g]]),
      .reg_data  (data[rd_num[g]]),
      .rob_valid (rob_valid[g]),
      .rob_data  (rob_data[g]),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .op        (op)
    );
    assign rd_valid[g] = op.valid;
    assign rd_tag[g] = op.tag;
    assign rd_data[g] = op.data;
    assign rob_tag[g] = op.tag;
  end
endmodule

// File: tb/tb_arch_reg_rename.sv
// tb_arch_reg_rename: directed stimulus checked against a behavioural rename-table model every cycle
module tb_arch_reg_rename;
  import arch_reg_rename_pkg::*;
  localparam int NR = 2;
  logic clk = 0, reset_n = 0, flush = 0;
  logic [REG_WIDTH-1:0] rd_num [NR];
  logic rd_valid [NR];
  logic [ROB_WIDTH-1:0] rd_tag [NR], rob_tag [NR];
  logic [DATA_WIDTH-1:0] rd_data [NR], rob_data [NR];
  logic rob_valid [NR];
  logic cdb_valid = 0, issue = 0, issue_dest_we = 0, commit = 0;
  logic [ROB_WIDTH-1:0] cdb_tag = 0, issue_tag = 0, commit_tag = 0;
  logic [DATA_WIDTH-1:0] cdb_data = 0, commit_data = 0;
  logic [REG_WIDTH-1:0] issue_dest = 0, commit_arch_num = 0;
  int checks = 0, fails = 0;

  arch_reg_rename #(.N_READ(NR), .HAS_ZERO(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .rd_num(rd_num), .rd_valid(rd_valid),
    .rd_tag(rd_tag), .rd_data(rd_data), .rob_tag(rob_tag), .rob_valid(rob_valid),
    .rob_data(rob_data), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue(issue), .issue_dest_we(issue_dest_we), .issue_dest(issue_dest), .issue_tag(issue_tag),
    .commit(commit), .commit_arch_num(commit_arch_num), .commit_tag(commit_tag),
    .commit_data(commit_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: committed value, whether a writer is outstanding, and the last tag handed out per register.
  logic [DATA_WIDTH-1:0] m_data [NUM_REGS];
  bit m_busy [NUM_REGS];
  logic [ROB_WIDTH-1:0] m_tag [NUM_REGS];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        m_data[r] = 0;
        m_busy[r] = 0;
        m_tag[r] = 0;
      end
    end else begin
      if (commit && commit_arch_num != 0) begin
        m_data[commit_arch_num] = commit_data;
        if (m_tag[commit_arch_num] == commit_tag) m_busy[commit_arch_num] = 0;
      end
      if (flush) begin
        for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 0;
      end else if (issue && issue_dest_we && issue_dest != 0) begin
        m_busy[issue_dest] = 1;
        m_tag[issue_dest] = issue_tag;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic ev;
    logic [DATA_WIDTH-1:0] ed;
    int r;
    if (reset_n) begin
      for (int p = 0; p < NR; p++) begin
        r = int'(rd_num[p]);
        ev = 1;
        ed = 0;
        if (r == 0) ed = 0;
        else if (!m_busy[r]) ed = m_data[r];
        else if (rob_valid[p]) ed = rob_data[p];
        else if (cdb_valid && cdb_tag == m_tag[r]) ed = cdb_data;
        else ev = 0;
        check($sformatf("model_valid[%0d]", p), 64'(rd_valid[p]), 64'(ev));
        if (ev) check($sformatf("model_data[%0d]", p), 64'(rd_data[p]), 64'(ed));
        else check($sformatf("model_tag[%0d]", p), 64'(rd_tag[p]), 64'(m_tag[r]));
        check($sformatf("model_rob_tag[%0d]", p), 64'(rob_tag[p]), 64'(m_tag[r]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    issue = 0; issue_dest_we = 0; commit = 0; flush = 0; cdb_valid = 0;
    for (int p = 0; p < NR; p++) rob_valid[p] = 0;
  endtask

  task automatic do_issue(input logic [REG_WIDTH-1:0] d, input logic [ROB_WIDTH-1:0] t);
    issue = 1; issue_dest_we = 1; issue_dest = d; issue_tag = t;
  endtask

  task automatic do_commit(input logic [REG_WIDTH-1:0] a, input logic [ROB_WIDTH-1:0] t,
                           input logic [DATA_WIDTH-1:0] d);
    commit = 1; commit_arch_num = a; commit_tag = t; commit_data = d;
  endtask

  initial begin
    for (int p = 0; p < NR; p++) begin
      rd_num[p] = REG_WIDTH'(p + 1);
      rob_valid[p] = 0;
      rob_data[p] = 0;
    end
    #12;
    for (int p = 0; p < NR; p++) begin
      check("reset_valid", 64'(rd_valid[p]), 64'd1);
      check("reset_data", 64'(rd_data[p]), 64'd0);
      check("reset_tag", 64'(rd_tag[p]), 64'd0);
      check("reset_rob_tag", 64'(rob_tag[p]), 64'd0);
    end
    reset_n = 1;
    tick;
    do_issue(3, 5);
    tick;
    idle;
    rd_num[0] = 3; rd_num[1] = 4;
    #1;
    check("pending_valid", 64'(rd_valid[0]), 64'd0);
    check("pending_tag", 64'(rd_tag[0]), 64'd5);
    check("pending_rob_tag", 64'(rob_tag[0]), 64'd5);
    check("other_reg_valid", 64'(rd_valid[1]), 64'd1);
    cdb_valid = 1; cdb_tag = 5; cdb_data = 32'hDEAD;
    #1;
    check("cdb_valid", 64'(rd_valid[0]), 64'd1);
    check("cdb_data", 64'(rd_data[0]), 64'hDEAD);
    rob_valid[0] = 1; rob_data[0] = 32'hBEEF;
    #1;
    check("rob_over_cdb", 64'(rd_data[0]), 64'hBEEF);
    tick;
    idle;
    cdb_valid = 1; cdb_tag = 6;
    #1;
    check("cdb_tag_miss", 64'(rd_valid[0]), 64'd0);
    tick;
    idle;
    do_commit(3, 5, 32'h1234);
    tick;
    idle;
    #1;
    check("commit_valid", 64'(rd_valid[0]), 64'd1);
    check("commit_data", 64'(rd_data[0]), 64'h1234);
    do_issue(3, 5);
    tick;
    do_issue(3, 6);
    tick;
    idle;
    do_commit(3, 5, 32'h77);
    tick;
    idle;
    #1;
    check("younger_valid", 64'(rd_valid[0]), 64'd0);
    check("younger_tag", 64'(rd_tag[0]), 64'd6);
    flush = 1;
    tick;
    idle;
    #1;
    check("stored_commit_data", 64'(rd_data[0]), 64'h77);
    do_issue(7, 2);
    do_commit(7, 1, 32'h11);
    tick;
    idle;
    rd_num[0] = 7;
    #1;
    check("issue_wins_valid", 64'(rd_valid[0]), 64'd0);
    check("issue_wins_tag", 64'(rd_tag[0]), 64'd2);
    flush = 1;
    do_commit(7, 2, 32'h55);
    do_issue(9, 3);
    tick;
    idle;
    rd_num[1] = 9;
    #1;
    check("flush_valid", 64'(rd_valid[0]), 64'd1);
    check("flush_commit_data", 64'(rd_data[0]), 64'h55);
    check("flush_blocks_issue", 64'(rd_valid[1]), 64'd1);
    do_issue(0, 4);
    do_commit(0, 4, 32'h99);
    tick;
    idle;
    rd_num[0] = 0; rd_num[1] = 0;
    rob_valid[1] = 1; rob_data[1] = 32'hAAAA;
    #1;
    for (int p = 0; p < NR; p++) begin
      check("zero_valid", 64'(rd_valid[p]), 64'd1);
      check("zero_data", 64'(rd_data[p]), 64'd0);
      check("zero_rob_tag", 64'(rob_tag[p]), 64'd0);
    end
    tick;
    idle;
    do_issue(5, 9);
    tick;
    idle;
    rd_num[0] = 5; rd_num[1] = 7;
    #1;
    check("pre_reset_busy", 64'(rd_valid[0]), 64'd0);
    reset_n = 0;
    #1;
    check("async_reset_valid", 64'(rd_valid[0]), 64'd1);
    check("async_reset_rob_tag", 64'(rob_tag[0]), 64'd0);
    check("async_reset_data", 64'(rd_data[1]), 64'd0);
    tick;
    reset_n = 1;
    tick;
    #1;
    check("post_reset_valid", 64'(rd_valid[0]), 64'd1);
    check("post_reset_data", 64'(rd_data[1]), 64'd0);
    repeat (2) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
